// File: rtl/shared_cmul_pkg.sv
// Shared definitions for the time-multiplexed butterfly engine.
//   ow_f     : output component width for a given input width / binary point
//   cw_f     : channel counter width (minimum 1 bit)
//   cplx_lsb : LSB offset of channel ch in a flat {re,im} per-channel bus
//   state_t  : batch sequencer states
package shared_cmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 2*W+1 bit product, shifted right by the binary point, plus one bit of
    // headroom for the add/sub with n.
    function automatic int ow_f(input int width, input int point);
        return 2 * width - point + 2;
    endfunction

    function automatic int cw_f(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Channel 0 sits in the LSBs; each channel is {re, im}, re in the upper half.
    function automatic int cplx_lsb(input int ch, input int comp_w);
        return ch * 2 * comp_w;
    endfunction

endpackage

// File: rtl/cmul_butterfly_core.sv
// Pipelined complex multiply + butterfly for one operand set per cycle.
//   r_p = n + m*w, r_m = n - m*w, all values at the same binary point.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid bits only)
//   in_valid, in_tag    operand set valid and its channel tag
//   m, n, w             {re,im} operands, P_WIDTH bits per component
//   out_valid, out_tag  result valid and tag, P_PIPE cycles after issue
//   r_p, r_m            {re,im} results, L_OW bits per component
//   busy                any pipeline stage holds a valid operand set
// Build option: SHARED_CMUL_ROUND_EN adds half an LSB before the binary-point
// shift (round half up); otherwise the shift truncates toward -inf.
module cmul_butterfly_core
    import shared_cmul_pkg::*;
#(
    parameter  int P_WIDTH = 8,
    parameter  int P_POINT = 6,
    parameter  int P_PIPE  = 2,
    parameter  int P_TAG_W = 2,
    localparam int L_OW    = ow_f(P_WIDTH, P_POINT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [P_TAG_W-1:0]   in_tag,
    input  logic [2*P_WIDTH-1:0] m,
    input  logic [2*P_WIDTH-1:0] n,
    input  logic [2*P_WIDTH-1:0] w,
    output logic                 out_valid,
    output logic [P_TAG_W-1:0]   out_tag,
    output logic [2*L_OW-1:0]    r_p,
    output logic [2*L_OW-1:0]    r_m,
    output logic                 busy
);

    localparam int PW = 2 * P_WIDTH + 1;  // full complex-product width
    localparam int WW = PW + 1;           // shift/round work width, always >= L_OW

    logic signed [P_WIDTH-1:0] m_re, m_im, w_re, w_im;
    logic signed [PW-1:0]      pr_c, pi_c;

    assign m_re = m[2*P_WIDTH-1:P_WIDTH];
    assign m_im = m[P_WIDTH-1:0];
    assign w_re = w[2*P_WIDTH-1:P_WIDTH];
    assign w_im = w[P_WIDTH-1:0];

    assign pr_c = PW'(m_re) * PW'(w_re) - PW'(m_im) * PW'(w_im);
    assign pi_c = PW'(m_re) * PW'(w_im) + PW'(m_im) * PW'(w_re);

    logic [P_PIPE:1]                vld_pipe;
    logic [P_PIPE:1][PW-1:0]        pr_q, pi_q;
    logic [P_PIPE:1][2*P_WIDTH-1:0] n_q;
    logic [P_PIPE:1][P_TAG_W-1:0]   tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            for (int s = 2; s <= P_PIPE; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // Data stages carry no reset: they are only observed under vld_pipe.
    always_ff @(posedge clk) begin
        pr_q[1]  <= pr_c;
        pi_q[1]  <= pi_c;
        n_q[1]   <= n;
        tag_q[1] <= in_tag;
        for (int s = 2; s <= P_PIPE; s++) begin
            pr_q[s]  <= pr_q[s-1];
            pi_q[s]  <= pi_q[s-1];
            n_q[s]   <= n_q[s-1];
            tag_q[s] <= tag_q[s-1];
        end
    end

    logic signed [WW-1:0]   pr_w, pi_w, pr_sh, pi_sh;
    logic signed [L_OW-1:0] p_re, p_im, n_re, n_im;

`ifdef SHARED_CMUL_ROUND_EN
    localparam int RND = (P_POINT > 0) ? (1 << (P_POINT - 1)) : 0;
    assign pr_w = WW'($signed(pr_q[P_PIPE])) + WW'(RND);
    assign pi_w = WW'($signed(pi_q[P_PIPE])) + WW'(RND);
`else
    assign pr_w = WW'($signed(pr_q[P_PIPE]));
    assign pi_w = WW'($signed(pi_q[P_PIPE]));
`endif

    assign pr_sh = pr_w >>> P_POINT;
    assign pi_sh = pi_w >>> P_POINT;

    // The shifted product fits in L_OW-1 bits and n in P_WIDTH bits, so the
    // L_OW-bit sum/difference cannot wrap.
    assign p_re = L_OW'(pr_sh);
    assign p_im = L_OW'(pi_sh);
    assign n_re = L_OW'($signed(n_q[P_PIPE][2*P_WIDTH-1:P_WIDTH]));
    assign n_im = L_OW'($signed(n_q[P_PIPE][P_WIDTH-1:0]));

    assign r_p       = {n_re + p_re, n_im + p_im};
    assign r_m       = {n_re - p_re, n_im - p_im};
    assign out_valid = vld_pipe[P_PIPE];
    assign out_tag   = tag_q[P_PIPE];
    assign busy      = |vld_pipe;

endmodule

// File: rtl/shared_cmul_butterfly_array.sv
// Radix-2 butterfly engine: one pipelined complex multiplier shared by
// P_CHANNELS operand sets per batch, issued one channel per cycle.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   i_valid, o_in_ready batch input handshake (ready only while idle)
//   i_m, i_n, i_w       per-channel {re,im} operands, channel 0 in LSBs
//   o_valid, i_ready    result batch handshake
//   o_r_p, o_r_m        per-channel {re,im} of n + m*w and n - m*w
// Build option: SHARED_CMUL_ROUND_EN selects round-half-up in the core
// (default: truncation). Latency is identical in both builds.
module shared_cmul_butterfly_array
    import shared_cmul_pkg::*;
#(
    parameter  int P_WIDTH    = 8,
    parameter  int P_POINT    = 6,
    parameter  int P_CHANNELS = 4,
    parameter  int P_PIPE     = 2,
    localparam int L_OW       = ow_f(P_WIDTH, P_POINT),
    localparam int L_CW       = cw_f(P_CHANNELS)
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             i_valid,
    output logic                             o_in_ready,
    input  logic [P_CHANNELS*2*P_WIDTH-1:0]  i_m,
    input  logic [P_CHANNELS*2*P_WIDTH-1:0]  i_n,
    input  logic [P_CHANNELS*2*P_WIDTH-1:0]  i_w,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [P_CHANNELS*2*L_OW-1:0]     o_r_p,
    output logic [P_CHANNELS*2*L_OW-1:0]     o_r_m
);

    localparam int IW  = 2 * P_WIDTH;
    localparam int OW2 = 2 * L_OW;

    state_t                         state;
    logic [L_CW-1:0]                cnt;
    logic [P_CHANNELS-1:0][IW-1:0]  bank_m, bank_n, bank_w;
    logic [P_CHANNELS-1:0][OW2-1:0] rp_bank, rm_bank;

    logic            issue;
    logic            core_valid, core_busy;
    logic [L_CW-1:0] core_tag;
    logic [OW2-1:0]  core_rp, core_rm;

    assign issue = (state == ISSUE);

    cmul_butterfly_core #(
        .P_WIDTH (P_WIDTH),
        .P_POINT (P_POINT),
        .P_PIPE  (P_PIPE),
        .P_TAG_W (L_CW)
    ) u_core (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (issue),
        .in_tag    (cnt),
        .m         (bank_m[cnt]),
        .n         (bank_n[cnt]),
        .w         (bank_w[cnt]),
        .out_valid (core_valid),
        .out_tag   (core_tag),
        .r_p       (core_rp),
        .r_m       (core_rm),
        .busy      (core_busy)
    );

    // Sequencer: capture -> issue one channel per cycle -> wait for the
    // pipeline to empty -> present the batch until accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            o_in_ready <= 1'b1;
            o_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    state      <= ISSUE;
                    cnt        <= '0;
                    o_in_ready <= 1'b0;
                end
                ISSUE: begin
                    if (cnt == L_CW'(P_CHANNELS - 1)) state <= DRAIN;
                    else                              cnt   <= cnt + L_CW'(1);
                end
                DRAIN: if (!core_busy) begin
                    state   <= DONE;
                    o_valid <= 1'b1;
                end
                DONE: if (i_ready) begin
                    state      <= IDLE;
                    o_valid    <= 1'b0;
                    o_in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input bank needs no reset: nothing reads it until a capture refills it.
    always_ff @(posedge CLK) begin
        if (!RST && state == IDLE && i_valid) begin
            for (int k = 0; k < P_CHANNELS; k++) begin
                bank_m[k] <= i_m[cplx_lsb(k, P_WIDTH) +: IW];
                bank_n[k] <= i_n[cplx_lsb(k, P_WIDTH) +: IW];
                bank_w[k] <= i_w[cplx_lsb(k, P_WIDTH) +: IW];
            end
        end
    end

    // Results land in their slot by tag; earlier batch values persist until
    // the matching channel of the next batch overwrites them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rp_bank <= '0;
            rm_bank <= '0;
        end else if (core_valid) begin
            rp_bank[core_tag] <= core_rp;
            rm_bank[core_tag] <= core_rm;
        end
    end

    for (genvar k = 0; k < P_CHANNELS; k++) begin : g_out
        assign o_r_p[cplx_lsb(k, L_OW) +: OW2] = rp_bank[k];
        assign o_r_m[cplx_lsb(k, L_OW) +: OW2] = rm_bank[k];
    end

endmodule
